// File: rtl/seg_pkg.sv
// Shared glyph table, display geometry and content record for the seven-segment scan driver.
package seg_pkg;

    localparam int NUM_SLOTS = 4;
    localparam int NUM_TUBES = 8;

    // Segment order {a,b,c,d,e,f,g}; the dp bit is appended by the driver.
    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_A     = 7'b1110111;
    localparam logic [6:0] SEG_B     = 7'b0011111;
    localparam logic [6:0] SEG_C     = 7'b1001110;
    localparam logic [6:0] SEG_D     = 7'b0111101;
    localparam logic [6:0] SEG_E     = 7'b1001111;
    localparam logic [6:0] SEG_F     = 7'b1000111;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    typedef struct packed {
        logic [4*NUM_TUBES-1:0] digits;
        logic [NUM_TUBES-1:0]   blank;
        logic [NUM_TUBES-1:0]   dp;
    } content_t;

endpackage

// File: rtl/seg_scan_driver_hex_decode.sv
// Combinational hex nibble to seven-segment glyph lookup.
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (nib)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Two-bank multiplexed scan driver; content swaps into the shadow register only at frame wraps.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int SLOT_CYCLES = 100000
)
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   load,
    input  logic [4*NUM_TUBES-1:0] digits_in,
    input  logic [NUM_TUBES-1:0]   blank_in,
    input  logic [NUM_TUBES-1:0]   dp_in,
    output logic                   load_ack,
    output logic                   frame_done,
    output logic [7:0]             digit1,
    output logic [7:0]             digit2,
    output logic [NUM_TUBES-1:0]   tube_sel
);

    localparam int CW = $clog2(SLOT_CYCLES);
    localparam logic [CW-1:0] CYC_LAST = CW'(SLOT_CYCLES - 1);

    content_t             pend, shadow;
    logic                 pend_vld;
    logic                 scan_on;
    logic [CW-1:0]        cyc;
    logic [1:0]           slot;
    logic                 run, slot_end, wrap, adopt;
    logic [3:0]           nib0, nib1;
    logic [6:0]           seg0, seg1;
    logic [NUM_TUBES-1:0] sel_nx;

    // scan_on delays counting by one cycle so a fresh enable starts with a full slot 0
    assign run      = enable && scan_on;
    assign slot_end = run && (cyc == CYC_LAST);
    assign wrap     = slot_end && (slot == 2'(NUM_SLOTS - 1));
    assign adopt    = pend_vld && (wrap || !enable);

    assign nib0 = shadow.digits[{1'b0, slot, 2'b00} +: 4];
    assign nib1 = shadow.digits[{1'b1, slot, 2'b00} +: 4];

    seg_hex_decode u_dec0 (.nib(nib0), .seg(seg0));
    seg_hex_decode u_dec1 (.nib(nib1), .seg(seg1));

    always_comb begin
        sel_nx = '0;
        sel_nx[{1'b0, slot}] = 1'b1;
        sel_nx[{1'b1, slot}] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_on <= 1'b0;
            cyc     <= '0;
            slot    <= '0;
        end else begin
            scan_on <= enable;
            if (!enable) begin
                cyc  <= '0;
                slot <= '0;
            end else if (scan_on) begin
                if (slot_end) begin
                    cyc  <= '0;
                    slot <= slot + 2'd1;
                end else begin
                    cyc <= cyc + 1'b1;
                end
            end
        end
    end

    // Adoption uses the pending content from before this edge, so a load on the wrap waits a frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend       <= '0;
            pend_vld   <= 1'b0;
            shadow     <= '0;
            load_ack   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            load_ack   <= adopt;
            frame_done <= wrap;
            if (adopt)
                shadow <= pend;
            if (load) begin
                pend     <= {digits_in, blank_in, dp_in};
                pend_vld <= 1'b1;
            end else if (adopt) begin
                pend_vld <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit1   <= '0;
            digit2   <= '0;
            tube_sel <= '0;
        end else if (run) begin
            digit1   <= shadow.blank[{1'b0, slot}] ? {SEG_BLANK, 1'b0}
                                                   : {seg0, shadow.dp[{1'b0, slot}]};
            digit2   <= shadow.blank[{1'b1, slot}] ? {SEG_BLANK, 1'b0}
                                                   : {seg1, shadow.dp[{1'b1, slot}]};
            tube_sel <= sel_nx;
        end else begin
            digit1   <= '0;
            digit2   <= '0;
            tube_sel <= '0;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed scenarios plus random load/enable traffic checked every cycle against a timeline model.
module tb_seg_scan_driver;

    localparam int SC    = 4;
    localparam int FRAME = 4 * SC;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        load = 1'b0;
    logic [31:0] digits_in = '0;
    logic [7:0]  blank_in = '0;
    logic [7:0]  dp_in = '0;
    logic        load_ack, frame_done;
    logic [7:0]  digit1, digit2, tube_sel;

    int checks = 0;
    int errors = 0;
    int acks = 0;
    bit watch_ones = 0;
    bit saw_ones = 0;

    seg_scan_driver #(.SLOT_CYCLES(SC)) dut (
        .clk(clk), .rst(rst), .enable(enable), .load(load),
        .digits_in(digits_in), .blank_in(blank_in), .dp_in(dp_in),
        .load_ack(load_ack), .frame_done(frame_done),
        .digit1(digit1), .digit2(digit2), .tube_sel(tube_sel)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1111110;  4'h1: return 7'b0110000;
            4'h2: return 7'b1101101;  4'h3: return 7'b1111001;
            4'h4: return 7'b0110011;  4'h5: return 7'b1011011;
            4'h6: return 7'b1011111;  4'h7: return 7'b1110000;
            4'h8: return 7'b1111111;  4'h9: return 7'b1111011;
            4'hA: return 7'b1110111;  4'hB: return 7'b0011111;
            4'hC: return 7'b1001110;  4'hD: return 7'b0111101;
            4'hE: return 7'b1001111;  default: return 7'b1000111;
        endcase
    endfunction

    // Model: m_t counts scanning cycles since enable took effect; slot and wrap follow by division.
    logic [31:0] m_pd, m_sd;
    logic [7:0]  m_pb, m_pdp, m_sb, m_sdp;
    bit          m_pv, m_prev;
    int          m_t, m_s;
    bit          m_scan, m_wrap, m_adopt;
    logic [7:0]  e_d1, e_d2, e_ts;
    logic        e_ack, e_fd;

    always_comb begin
        m_scan  = enable && m_prev;
        m_s     = (m_t / SC) % 4;
        m_wrap  = m_scan && (m_t % FRAME == FRAME - 1);
        m_adopt = m_pv && (m_wrap || !enable);
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pd <= '0; m_pb <= '0; m_pdp <= '0; m_pv <= 0;
            m_sd <= '0; m_sb <= '0; m_sdp <= '0;
            m_t <= 0; m_prev <= 0;
            e_d1 <= '0; e_d2 <= '0; e_ts <= '0; e_ack <= 0; e_fd <= 0;
        end else begin
            if (m_scan) begin
                e_ts <= 8'(1 << m_s) | 8'(1 << (m_s + 4));
                e_d1 <= m_sb[m_s]     ? 8'h00 : {glyph(m_sd[4*m_s +: 4]), m_sdp[m_s]};
                e_d2 <= m_sb[m_s + 4] ? 8'h00 : {glyph(m_sd[4*(m_s+4) +: 4]), m_sdp[m_s + 4]};
            end else begin
                e_ts <= '0; e_d1 <= '0; e_d2 <= '0;
            end
            e_fd  <= m_wrap;
            e_ack <= m_adopt;
            if (m_adopt) begin
                m_sd <= m_pd; m_sb <= m_pb; m_sdp <= m_pdp;
            end
            if (load) begin
                m_pd <= digits_in; m_pb <= blank_in; m_pdp <= dp_in; m_pv <= 1;
            end else if (m_adopt) begin
                m_pv <= 0;
            end
            m_t    <= m_scan ? m_t + 1 : 0;
            m_prev <= enable;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("digit1", digit1, e_d1);
            chk("digit2", digit2, e_d2);
            chk("tube_sel", tube_sel, e_ts);
            chk("load_ack", 8'(load_ack), 8'(e_ack));
            chk("frame_done", 8'(frame_done), 8'(e_fd));
            if (load_ack) acks++;
            if (watch_ones && (digit1 == 8'h60 || digit2 == 8'h60)) saw_ones = 1;
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_ack(input string nm);
        int n = 0;
        while (load_ack !== 1'b1 && n < 3 * FRAME) begin
            @(negedge clk);
            n++;
        end
        chk(nm, 8'(load_ack), 8'd1);
    endtask

    task automatic wait_fd(input string nm);
        int n = 0;
        while (frame_done !== 1'b1 && n < 3 * FRAME) begin
            @(negedge clk);
            n++;
        end
        chk(nm, 8'(frame_done), 8'd1);
    endtask

    task automatic do_load(input logic [31:0] d, input logic [7:0] b, input logic [7:0] p);
        load = 1; digits_in = d; blank_in = b; dp_in = p;
        step(1);
        load = 0; blank_in = '0; dp_in = '0;
    endtask

    initial begin
        int a0;
        step(3);
        rst = 0;
        step(1);
        chk("rst_tube_sel", tube_sel, 8'h00);
        chk("rst_digit1", digit1, 8'h00);
        chk("rst_load_ack", 8'(load_ack), 8'd0);
        chk("model_rst_ts", e_ts, 8'h00);

        // Reset mid-scan, then restart
        enable = 1;
        step(7);
        #2 rst = 1;
        #1;
        chk("midrst_tube_sel", tube_sel, 8'h00);
        chk("midrst_digit1", digit1, 8'h00);
        chk("midrst_digit2", digit2, 8'h00);
        step(1);
        rst = 0;
        step(1);
        chk("restart_dark", tube_sel, 8'h00);
        step(1);
        chk("restart_ts", tube_sel, 8'h11);

        // Full scan from content loaded while disabled
        enable = 0;
        step(1);
        do_load(32'h76543210, 8'h00, 8'h00);
        step(1);
        chk("dis_adopt_ack", 8'(load_ack), 8'd1);
        enable = 1;
        step(2);
        chk("s0_ts", tube_sel, 8'h11); chk("s0_d1", digit1, 8'hFC); chk("s0_d2", digit2, 8'h66);
        chk("model_s0_d2", e_d2, 8'h66);
        step(4);
        chk("s1_ts", tube_sel, 8'h22); chk("s1_d1", digit1, 8'h60); chk("s1_d2", digit2, 8'hB6);
        step(4);
        chk("s2_ts", tube_sel, 8'h44); chk("s2_d1", digit1, 8'hDA); chk("s2_d2", digit2, 8'hBE);
        step(4);
        chk("s3_ts", tube_sel, 8'h88); chk("s3_d1", digit1, 8'hF2); chk("s3_d2", digit2, 8'hE0);
        step(3);
        chk("fd_first", 8'(frame_done), 8'd1);
        step(1);
        chk("fd_low", 8'(frame_done), 8'd0);
        step(15);
        chk("fd_period", 8'(frame_done), 8'd1);

        // Deferred adoption
        step(5);
        a0 = acks;
        do_load(32'h88888888, 8'h00, 8'h00);
        wait_ack("defer_ack");
        step(1);
        chk("defer_d1", digit1, 8'hFE); chk("defer_d2", digit2, 8'hFE);
        step(FRAME);
        chk("defer_ack_count", 8'(acks - a0), 8'd1);

        // Overwrite before adoption
        wait_fd("ovr_frame");
        step(2);
        watch_ones = 1;
        a0 = acks;
        do_load(32'h11111111, 8'h00, 8'h00);
        step(2);
        do_load(32'hEEEEEEEE, 8'h00, 8'h00);
        wait_ack("ovr_ack");
        step(1);
        chk("ovr_d1", digit1, 8'h9E); chk("ovr_d2", digit2, 8'h9E);
        step(FRAME);
        watch_ones = 0;
        chk("ovr_ack_count", 8'(acks - a0), 8'd1);
        chk("ovr_no_ones", 8'(saw_ones), 8'd0);

        // Blank and decimal point
        do_load(32'h00000000, 8'h01, 8'h10);
        wait_ack("bdp_ack");
        step(1);
        chk("bdp_d1", digit1, 8'h00); chk("bdp_d2", digit2, 8'hFD); chk("bdp_ts", tube_sel, 8'h11);

        // Load coincident with wrap while pending is valid, then disable
        wait_fd("wrap_frame");
        step(2);
        do_load(32'h22222222, 8'h00, 8'h00);
        step(12);
        do_load(32'hFFFFFFFF, 8'h00, 8'h00);
        chk("wrap_ack_old", 8'(load_ack), 8'd1);
        chk("wrap_fd", 8'(frame_done), 8'd1);
        step(1);
        chk("wrap_old_d1", digit1, 8'hDA);
        step(15);
        chk("wrap_ack_new", 8'(load_ack), 8'd1);
        step(1);
        chk("wrap_new_d1", digit1, 8'h8E); chk("wrap_new_d2", digit2, 8'h8E);
        enable = 0;
        step(1);
        chk("off_d1", digit1, 8'h00); chk("off_d2", digit2, 8'h00); chk("off_ts", tube_sel, 8'h00);

        // Random traffic
        enable = 1;
        for (int i = 0; i < 2500; i++) begin
            step(1);
            load = ($urandom_range(7) == 0);
            if (load) begin
                digits_in = $urandom;
                blank_in  = 8'($urandom) & 8'($urandom);
                dp_in     = 8'($urandom);
            end
            if ($urandom_range(79) == 0) enable = ~enable;
            if ($urandom_range(599) == 0) begin
                #2 rst = 1;
                #2 rst = 0;
            end
        end
        load = 0;
        step(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Multiplexed scan driver for the eight-tube, two-bank seven-segment display. It is the producing end of the `digit1`/`digit2`/`tube_sel` bus that the top-level display mux forwards to the pins. It takes eight hex nibbles plus blank and decimal-point masks from a content module (clock, timer, gear, self-clean countdown) and time-multiplexes them onto the two segment buses. New content is adopted only at frame boundaries, so the display never tears.

## Interface
Parameters:
- `SLOT_CYCLES`, default 100000: clock cycles per scan slot (1 ms at 100 MHz); legal minimum 2.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `enable`  in  1  scanning enabled; low forces a dark display.
- `load`  in  1  single-cycle request to capture `digits_in`, `blank_in` and `dp_in`.
- `digits_in`  in  32  nibble k (bits 4k+3:4k) is the hex value for tube k.
- `blank_in`  in  8  bit k = 1 blanks tube k (segments and dp).
- `dp_in`  in  8  bit k = 1 lights the decimal point of tube k.
- `load_ack`  out  1  one-cycle pulse when captured content becomes the displayed content.
- `frame_done`  out  1  one-cycle pulse at every slot-3 to slot-0 wrap.
- `digit1`  out  8  segments for bank 0 (tubes 0–3), bit order {a,b,c,d,e,f,g,dp}, active high.
- `digit2`  out  8  segments for bank 1 (tubes 4–7), same encoding.
- `tube_sel`  out  8  one-hot per bank, active high; bit k enables tube k.

## Operation
- **Registers.**
  - Pending register: captures the inputs on `load`.
  - Pending-valid flag.
  - Shadow (displayed) register.
  - Slot counter `cyc` (0..SLOT_CYCLES-1).
  - Slot index `slot` (0..3).
- **Scan.** In slot s, tube s (bank 0) and tube s+4 (bank 1) are lit together. Each frame is 4 slots.
- **Decode.** The nibble from the shadow register is decoded to a hex glyph. Required glyphs:
  - 0 = 11111100, 1 = 01100000, 2 = 11011010, 8 = 11111110, E = 10011110, F = 10001110.
  - All other digits use standard a–g patterns.
  - The dp bit is ORed in from `dp_in`.
  - A blanked tube drives 00000000 on its bank's segment bus, and its `tube_sel` bit is still asserted.
- **Load handshake.**
  - `load` = 1 copies the inputs into the pending register and sets pending-valid.
  - A second `load` before adoption overwrites the pending register; only the latest content is shown, and one `load_ack` is issued.
- **Adoption.**
  - With `enable` = 1, pending content is adopted at the frame wrap: shadow <= pending, pending-valid cleared, `load_ack` pulsed.
  - With `enable` = 0, adoption happens on the cycle after the capture.
- **Same-cycle load and wrap.** If `load` and a frame wrap fall in the same cycle, the old pending content (if valid) is adopted. The new content is held pending for the next wrap.
- **Disable.** `enable` = 0 clears `cyc` and `slot` to 0 and forces `digit1`, `digit2` and `tube_sel` to 0 on the next edge.
- **Re-enable.** On re-enable, scanning restarts at slot 0 with a full-length slot.

## Timing
- **Reset values** (all registers cleared asynchronously):
  - `digit1`, `digit2`, `tube_sel` = 0.
  - `load_ack`, `frame_done` = 0.
  - `cyc`, `slot` = 0.
  - Pending, pending-valid and shadow = 0.
- **Slot counter.** `cyc` increments every cycle while enabled. At SLOT_CYCLES-1 it wraps to 0 and `slot` advances, 3 wraps to 0.
- **Output latency.** `digit1`, `digit2` and `tube_sel` are registered from `slot` and the shadow register, one cycle after they change. The first lit output appears 2 cycles after `enable` rises.
- **Pulse alignment.** `frame_done` and `load_ack` are registered pulses, asserted the cycle after the wrap edge.
- **Adoption latency.** Worst case from `load` to `load_ack` is 4·SLOT_CYCLES + 1 cycles.
- **Reset mid-frame.** Reset during a frame discards pending content. No `load_ack` is issued for it.

## Structure
- Package `seg_pkg`:
  - glyph constants `SEG_0`…`SEG_F` and `SEG_BLANK`;
  - `NUM_SLOTS` = 4 and `NUM_TUBES` = 8.
- Sub-module `seg_hex_decode`: combinational 4-bit to 7-bit glyph lookup, instantiated twice, once per bank.
- Everything else (counters, handshake, output registers) lives in `seg_scan_driver`.

## Test plan
All scenarios use SLOT_CYCLES = 4.
1. **Reset.** Assert `rst` mid-scan -> all outputs 0 immediately. After release with `enable` = 1, `tube_sel` = 00010001 appears 2 cycles later.
2. **Full scan.** Load digits 0x76543210 with `enable` = 0, then raise `enable` -> `tube_sel` steps 00010001, 00100010, 01000100, 10001000 every 4 cycles. In slot 0, `digit1` = 11111100 and `digit2` = 0x66 (glyph 4). `frame_done` pulses every 16 cycles.
3. **Deferred adoption.** Mid-frame `load` of 0x88888888 -> display unchanged until the wrap. `load_ack` pulses once, then `digit1` = `digit2` = 11111110.
4. **Overwrite before adoption.** Two `load`s (0x11111111 then 0xEEEEEEEE) in the same frame -> a single `load_ack`; displays 10011110 on both banks and never shows the 1s.
5. **Blank and dp.** `blank_in` = 0x01 and `dp_in` = 0x10 on 0x00000000 -> slot 0 gives `digit1` = 0 and `digit2` = 11111101, with `tube_sel` = 00010001.
6. **Load on wrap, then disable.** `load` coincident with a wrap while pending is valid -> the older content is adopted now and the newer one at the next wrap. Dropping `enable` -> outputs 0 within 1 cycle.
